// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Imported by the fetch FSM and its wait timer.
package fetch_pkg;

  localparam int unsigned INSN_BYTES = 4;
  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALT,
    FAULT
  } fetch_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_TIMEOUT  = 2'd2
  } fault_cause_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts consecutive unanswered FETCH cycles and flags the MAX_WAIT-th one.
// The terminal flag is qualified by enable so it only fires while fetching.
module fetch_wait_timer
  import fetch_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic pc_clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [WAIT_CNT_W-1:0] LAST_COUNT = WAIT_CNT_W'(MAX_WAIT - 1);

  logic [WAIT_CNT_W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge pc_clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of FETCH cycles already elapsed, so the current
  // cycle is the MAX_WAIT-th when count == MAX_WAIT-1.
  assign terminal = enable && (count == LAST_COUNT);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, requests words from imem, buffers
// one instruction for decode and handles redirect, halt and fetch faults.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic        pc_clk,
  input  logic        reset_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic [31:0] pc_out,
  output logic        halted,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  fetch_state_t state, state_n;
  fault_cause_t cause, cause_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  instr_q, instr_n;
  logic [31:0]  instr_pc_q, instr_pc_n;
  logic         timer_clear;
  logic         timer_en;
  logic         timer_terminal;

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .pc_clk   (pc_clk),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .enable   (timer_en),
    .terminal (timer_terminal)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    cause_n     = cause;
    pc_n        = pc;
    instr_n     = instr_q;
    instr_pc_n  = instr_pc_q;
    timer_clear = 1'b1;
    timer_en    = 1'b0;

    unique case (state)
      IDLE: begin
        pc_n = RESET_VECTOR;
        if (run) state_n = FETCH;
      end

      FETCH: begin
        timer_clear = 1'b0;
        timer_en    = 1'b1;
        if (redirect_valid) begin
          // Same-cycle rdata is discarded; the target is fetched afresh.
          timer_clear = 1'b1;
          if (!is_word_aligned(redirect_target)) begin
            state_n = FAULT;
            cause_n = FC_MISALIGN;
          end else begin
            pc_n = redirect_target;
          end
        end else if (halt_req) begin
          state_n = HALT;
        end else if (imem_ready) begin
          timer_clear = 1'b1;
          instr_n     = imem_rdata;
          instr_pc_n  = pc;
          state_n     = ISSUE;
        end else if (timer_terminal) begin
          state_n = FAULT;
          cause_n = FC_TIMEOUT;
        end
      end

      ISSUE: begin
        if (redirect_valid) begin
          // The buffered instruction is on the wrong path: drop it even if
          // decode is accepting this cycle.
          if (!is_word_aligned(redirect_target)) begin
            state_n = FAULT;
            cause_n = FC_MISALIGN;
          end else begin
            pc_n    = redirect_target;
            state_n = FETCH;
          end
        end else if (halt_req) begin
          if (instr_ready) pc_n = pc + 32'(INSN_BYTES);
          state_n = HALT;
        end else if (instr_ready) begin
          pc_n    = pc + 32'(INSN_BYTES);
          state_n = FETCH;
        end
      end

      HALT, FAULT: begin
        state_n = state;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge pc_clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cause      <= FC_NONE;
      pc         <= RESET_VECTOR;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state      <= state_n;
      cause      <= cause_n;
      pc         <= pc_n;
      instr_q    <= instr_n;
      instr_pc_q <= instr_pc_n;
    end
  end

  // All outputs decode registered state only.
  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign pc_out      = pc;
  assign instr_valid = (state == ISSUE);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = (state == HALT);
  assign fetch_fault = (state == FAULT);
  assign fault_cause = cause;

endmodule
